// File: rtl/comp_seq.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, signed or unsigned.
// Optional build macro EARLY_EXIT_EN ends the compare at the first differing digit.
module comp_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             E,
  output logic             G,
  output logic             L
);

  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic [2:0]       egl_q, egl_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] da, db;
  logic             gt_n, lt_n;
  logic             last;

  // Current digit compare; flags are sticky once either is set.
  always_comb begin
    da   = a_q[int'(idx_q) * DIGIT +: DIGIT];
    db   = b_q[int'(idx_q) * DIGIT +: DIGIT];
    gt_n = gt_q | (~gt_q & ~lt_q & (da > db));
    lt_n = lt_q | (~gt_q & ~lt_q & (da < db));
`ifdef EARLY_EXIT_EN
    last = (idx_q == '0) | gt_n | lt_n;
`else
    last = (idx_q == '0);
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    egl_d   = egl_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = sgn ? (A ^ MSB_MASK) : A;
          b_d     = sgn ? (B ^ MSB_MASK) : B;
          idx_d   = IDX_W'(N - 1);
          gt_d    = 1'b0;
          lt_d    = 1'b0;
        end
      end
      RUN: begin
        gt_d  = gt_n;
        lt_d  = lt_n;
        idx_d = idx_q - IDX_W'(1);
        if (last) begin
          egl_d   = {~gt_n & ~lt_n, gt_n, lt_n};
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and visible result registers; reset aborts any compare in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      egl_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      egl_q   <= egl_d;
    end
  end

  // Operand and scan registers are reloaded on every accept, so they need no reset.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    idx_q <= idx_d;
    gt_q  <= gt_d;
    lt_q  <= lt_d;
  end

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign {E, G, L} = egl_q;

endmodule

// File: tb/tb_comp_seq.sv
// Randomised self-checking bench for comp_seq: three builds (8/1, 16/4, 4/4) against
// a plain-arithmetic reference of result and done latency.
module tb_comp_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       st0, st1, st2, sg0, sg1, sg2;
  logic [7:0] a0, b0;
  logic [15:0] a1, b1;
  logic [3:0] a2, b2;
  wire        bz0, bz1, bz2, dn0, dn1, dn2;
  wire  [2:0] r0, r1, r2;

  comp_seq #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst(rst), .start(st0), .sgn(sg0), .A(a0), .B(b0),
    .busy(bz0), .done(dn0), .E(r0[2]), .G(r0[1]), .L(r0[0]));
  comp_seq #(.WIDTH(16), .DIGIT(4)) u1 (
    .clk(clk), .rst(rst), .start(st1), .sgn(sg1), .A(a1), .B(b1),
    .busy(bz1), .done(dn1), .E(r1[2]), .G(r1[1]), .L(r1[0]));
  comp_seq #(.WIDTH(4), .DIGIT(4)) u2 (
    .clk(clk), .rst(rst), .start(st2), .sgn(sg2), .A(a2), .B(b2),
    .busy(bz2), .done(dn2), .E(r2[2]), .G(r2[1]), .L(r2[0]));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int wid(int w);
    case (w)
      0: return 8;
      1: return 16;
      default: return 4;
    endcase
  endfunction

  function automatic int dig(int w);
    case (w)
      0: return 1;
      1: return 4;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] g_busy(int w);
    case (w)
      0: return 32'(bz0);
      1: return 32'(bz1);
      default: return 32'(bz2);
    endcase
  endfunction

  function automatic logic [31:0] g_done(int w);
    case (w)
      0: return 32'(dn0);
      1: return 32'(dn1);
      default: return 32'(dn2);
    endcase
  endfunction

  function automatic logic [31:0] g_egl(int w);
    case (w)
      0: return 32'(r0);
      1: return 32'(r1);
      default: return 32'(r2);
    endcase
  endfunction

  task automatic set_in(int w, logic [15:0] a, logic [15:0] b, logic s, logic st);
    case (w)
      0: begin a0 = a[7:0]; b0 = b[7:0]; sg0 = s; st0 = st; end
      1: begin a1 = a;      b1 = b;      sg1 = s; st1 = st; end
      default: begin a2 = a[3:0]; b2 = b[3:0]; sg2 = s; st2 = st; end
    endcase
  endtask

  // Reference: numeric compare of the operands as integers, latency from leading equal digits.
  function automatic void model(int w, logic [15:0] a, logic [15:0] b, logic s,
                                output logic [31:0] egl, output int lat);
    int     wd  = wid(w);
    int     dg  = dig(w);
    int     n   = wd / dg;
    int     cnt = 0;
    int     dm  = (1 << dg) - 1;
    longint va, vb;
    va = longint'(a) & ((64'sd1 << wd) - 1);
    vb = longint'(b) & ((64'sd1 << wd) - 1);
    if (s && va >= (64'sd1 << (wd - 1))) va = va - (64'sd1 << wd);
    if (s && vb >= (64'sd1 << (wd - 1))) vb = vb - (64'sd1 << wd);
    egl = (va == vb) ? 32'd4 : (va > vb) ? 32'd2 : 32'd1;
    for (int k = n - 1; k >= 0; k--) begin
      if (((int'(a) >> (k * dg)) & dm) == ((int'(b) >> (k * dg)) & dm)) cnt++;
      else break;
    end
`ifdef EARLY_EXIT_EN
    lat = (cnt == n) ? n : cnt + 1;
`else
    lat = n;
`endif
  endfunction

  task automatic kick(int w, logic [15:0] a, logic [15:0] b, logic s);
    set_in(w, a, b, s, 1'b1);
    @(negedge clk);
    set_in(w, a, b, s, 1'b0);
    chk($sformatf("busy%0d", w), g_busy(w), 32'd1);
  endtask

  task automatic launch(int w, logic [15:0] a, logic [15:0] b, logic s);
    @(negedge clk);
    kick(w, a, b, s);
  endtask

  // Waits for done while scrambling inputs (including start) to prove they are ignored.
  task automatic finish(int w, int cyc0, logic [31:0] egl, int lat, string tag);
    int cyc = cyc0;
    while (g_done(w) != 32'd1 && cyc < 40) begin
      set_in(w, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk);
      cyc++;
    end
    set_in(w, 16'd0, 16'd0, 1'b0, 1'b0);
    chk({tag, " lat"}, 32'(cyc), 32'(lat));
    chk({tag, " egl"}, g_egl(w), egl);
    chk({tag, " onehot"}, 32'($countones(g_egl(w))), 32'd1);
  endtask

  task automatic cmp(int w, logic [15:0] a, logic [15:0] b, logic s, string tag);
    logic [31:0] egl;
    int          lat;
    model(w, a, b, s, egl, lat);
    launch(w, a, b, s);
    finish(w, 0, egl, lat, tag);
    @(negedge clk);
    chk({tag, " pulse"}, g_done(w), 32'd0);
  endtask

  // Result must not move except with done or reset.
  logic [31:0] held [3];
  bit          mon = 1'b0;
  always @(negedge clk) begin
    if (mon) begin
      for (int i = 0; i < 3; i++) begin
        if (rst) held[i] <= 32'd0;
        else if (g_done(i) == 32'd1) held[i] <= g_egl(i);
        else chk($sformatf("hold%0d", i), g_egl(i), held[i]);
      end
    end
  end

  initial begin
    logic [31:0] egl;
    logic [15:0] ra, rb;
    int          lat;
    int          cnt;
    for (int w = 0; w < 3; w++) set_in(w, 16'd0, 16'd0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("rst busy%0d", w), g_busy(w), 32'd0);
      chk($sformatf("rst done%0d", w), g_done(w), 32'd0);
      chk($sformatf("rst egl%0d", w), g_egl(w), 32'd0);
    end
    mon = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;

    cmp(0, 16'h80, 16'h7F, 1'b0, "t1");
    cmp(0, 16'h80, 16'h7F, 1'b1, "t2a");
    cmp(0, 16'h5A, 16'h5A, 1'b1, "t2b");
    cmp(0, 16'h00, 16'h80, 1'b0, "t3a");
    cmp(0, 16'hFF, 16'hFF, 1'b0, "t3b");
    cmp(1, 16'hFFFF, 16'h0001, 1'b1, "t4");
    cmp(1, 16'h1234, 16'h1234, 1'b0, "t4eq");
    cmp(2, 16'h8, 16'h7, 1'b1, "n1a");
    cmp(2, 16'h3, 16'h3, 1'b0, "n1b");

    // Start during busy is ignored; start in the done cycle is accepted.
    model(0, 16'h10, 16'h20, 1'b0, egl, lat);
    launch(0, 16'h10, 16'h20, 1'b0);
    set_in(0, 16'h00, 16'h00, 1'b0, 1'b1);
    @(negedge clk);
    set_in(0, 16'h00, 16'h00, 1'b0, 1'b0);
    finish(0, 1, egl, lat, "t5a");
    model(0, 16'hC3, 16'h3C, 1'b1, egl, lat);
    kick(0, 16'hC3, 16'h3C, 1'b1);
    finish(0, 0, egl, lat, "t5b");
    @(negedge clk);
    chk("t5b pulse", g_done(0), 32'd0);

    // Reset mid-compare aborts with no done.
    launch(0, 16'h01, 16'h02, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6 busy", g_busy(0), 32'd0);
    chk("t6 done", g_done(0), 32'd0);
    chk("t6 egl", g_egl(0), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("t6 nodone", g_done(0), 32'd0);
    end
    cmp(0, 16'h40, 16'h41, 1'b0, "t6c");

    // Start held high on the single-digit build: a compare every other cycle.
    @(negedge clk);
    set_in(2, 16'h5, 16'h9, 1'b0, 1'b1);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (g_done(2) == 32'd1) begin
        cnt++;
        chk("hs egl", g_egl(2), 32'd1);
      end
    end
    set_in(2, 16'd0, 16'd0, 1'b0, 1'b0);
    chk("hs count", 32'(cnt), 32'd3);

    for (int i = 0; i < 270; i++) begin
      int w;
      w  = (i < 150) ? 0 : (i < 230) ? 1 : 2;
      ra = 16'($urandom);
      case ($urandom_range(3))
        0: rb = ra;
        1: rb = ra ^ (16'd1 << $urandom_range(wid(w) - 1));
        default: rb = 16'($urandom);
      endcase
      cmp(w, ra, rb, 1'($urandom), $sformatf("rnd%0d_%0d", w, i));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
